// File: rtl/ep2_arb_pkg.sv
// Shared definitions for the ep2 front-end arbiters: state encoding and
// index-width helper.
package ep2_arb_pkg;

   // Arbiter state encoding (legacy-compatible 1-bit constants).
   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   // Width of a port index; never returns 0 so single-port builds still
   // get a legal vector.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Cyclic priority search: returns the first set request at or after ptr.
// Purely combinational so it can sit inside a zero-latency grant path.
module rr_priority_select #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = 2
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic                 valid,
   output logic [IDX_W-1:0]     idx
);

   logic [2*NUM_PORTS-1:0] req_dbl;
   logic [NUM_PORTS-1:0]   req_rot;
   logic [IDX_W-1:0]       offset;
   logic [IDX_W:0]         sum;

   // Rotate the request vector so that position ptr lands at bit 0.
   assign req_dbl = {req, req};
   assign req_rot = req_dbl[ptr +: NUM_PORTS];

   // Lowest set bit of the rotated vector, mapped back to a port index.
   always_comb begin
      valid  = |req;
      offset = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            offset = IDX_W'(k);
         end
      end
      sum = {1'b0, ptr} + {1'b0, offset};
      if (sum >= (IDX_W+1)'(NUM_PORTS)) begin
         sum = sum - (IDX_W+1)'(NUM_PORTS);
      end
      idx = sum[IDX_W-1:0];
   end

endmodule

// File: rtl/guard_rr_arbiter.sv
// Packet-atomic round-robin arbiter with a per-packet condition guard.
// Forwarded packets pass through combinationally; dropped packets are
// drained at one beat per cycle independent of downstream ready.
module guard_rr_arbiter
   import ep2_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int IF_STREAM  = 1,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   input  logic [NUM_PORTS-1:0]            s_cond_tdata,
   input  logic [NUM_PORTS-1:0]            s_cond_tvalid,
   output logic [NUM_PORTS-1:0]            s_cond_tready,
   output logic [DATA_WIDTH-1:0]           m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]           m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic                            m_axis_tvalid,
   output logic [$clog2(NUM_PORTS)-1:0]    m_axis_tuser,
   input  logic                            m_axis_tready,
   output logic [CNT_WIDTH-1:0]            fwd_pkt_cnt,
   output logic [CNT_WIDTH-1:0]            drop_pkt_cnt
);

   localparam int IDX_W = idx_width(NUM_PORTS);

   logic [0:0]            state_reg;
   logic [IDX_W-1:0]      grant_reg;
   logic                  cond_reg;
   logic [IDX_W-1:0]      rr_ptr_reg;
   logic [CNT_WIDTH-1:0]  fwd_cnt_reg;
   logic [CNT_WIDTH-1:0]  drop_cnt_reg;

   logic [NUM_PORTS-1:0]  eligible;
   logic                  sel_valid;
   logic [IDX_W-1:0]      sel_idx;
   logic                  locked;
   logic [IDX_W-1:0]      cur_idx;
   logic                  cur_cond;
   logic                  cur_last;
   logic                  beat_valid;
   logic                  port_ready;
   logic                  serve_ready;
   logic                  xfer;
   logic                  pkt_done;
   logic [IDX_W-1:0]      rr_ptr_next;

   logic [DATA_WIDTH-1:0] data_arr [NUM_PORTS];
   logic [KEEP_WIDTH-1:0] keep_arr [NUM_PORTS];

   // A port may only compete once both its beat and its guard token are present.
   assign eligible = s_axis_tvalid & s_cond_tvalid;

   rr_priority_select #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_select (
      .req   (eligible),
      .ptr   (rr_ptr_reg),
      .valid (sel_valid),
      .idx   (sel_idx)
   );

   assign locked     = (state_reg == ST_LOCKED);
   assign cur_idx    = locked ? grant_reg : sel_idx;
   assign cur_cond   = locked ? cond_reg : s_cond_tdata[sel_idx];
   assign beat_valid = locked ? s_axis_tvalid[grant_reg] : sel_valid;

   // rst is active-low: while it is held, nothing is offered or accepted.
   // Dropped beats ignore downstream backpressure.
   assign port_ready  = rst && (cur_cond ? m_axis_tready : 1'b1);
   assign serve_ready = port_ready && (locked || sel_valid);
   assign xfer        = beat_valid && port_ready;
   assign pkt_done    = xfer && cur_last;

   assign rr_ptr_next = (cur_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : cur_idx + IDX_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign data_arr[gi]      = s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
         assign keep_arr[gi]      = s_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
         assign s_axis_tready[gi] = serve_ready && (cur_idx == IDX_W'(gi));
         // Tokens are consumed only with the first beat of a packet.
         assign s_cond_tready[gi] = serve_ready && !locked && (cur_idx == IDX_W'(gi));
      end

      if (IF_STREAM != 0) begin : g_stream
         assign cur_last     = s_axis_tlast[cur_idx];
         assign m_axis_tkeep = keep_arr[cur_idx];
      end else begin : g_single
         // Every beat is a whole packet in single-beat mode.
         assign cur_last     = 1'b1;
         assign m_axis_tkeep = '1;
      end
   endgenerate

   assign m_axis_tdata  = data_arr[cur_idx];
   assign m_axis_tlast  = cur_last;
   assign m_axis_tuser  = cur_idx;
   assign m_axis_tvalid = rst && beat_valid && cur_cond;

   // Packet lock: enter on a non-last first beat, leave on the last beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
         grant_reg <= '0;
         cond_reg  <= 1'b0;
      end else if (!locked) begin
         if (xfer && !cur_last) begin
            state_reg <= ST_LOCKED;
            grant_reg <= sel_idx;
            cond_reg  <= cur_cond;
         end
      end else if (pkt_done) begin
         state_reg <= ST_IDLE;
      end
   end

   // Round-robin pointer moves past the port whose packet just completed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_reg <= '0;
      end else if (pkt_done) begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // Saturating per-outcome packet counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd_cnt_reg  <= '0;
         drop_cnt_reg <= '0;
      end else if (pkt_done) begin
         if (cur_cond) begin
            if (fwd_cnt_reg != '1) fwd_cnt_reg <= fwd_cnt_reg + CNT_WIDTH'(1);
         end else begin
            if (drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
         end
      end
   end

   assign fwd_pkt_cnt  = fwd_cnt_reg;
   assign drop_pkt_cnt = drop_cnt_reg;

endmodule

// File: doc/guard_rr_arbiter.md
# guard_rr_arbiter

Packet-atomic round-robin arbiter that shares one guarded output stream between `NUM_PORTS` requesters. Each requester presents an AXI-Stream packet plus a 1-bit condition token per packet. The arbiter grants one requester per packet and holds the grant until `tlast`. Packets with condition 1 are forwarded; packets with condition 0 are consumed and dropped without waiting on the downstream. It sits in front of an ep2 handler input, replacing one guard per producer plus a separate mux.

## Interface
- `NUM_PORTS`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 512: beat width in bits.
- `KEEP_WIDTH`, `DATA_WIDTH/8`: tkeep width.
- `IF_STREAM`, 1: 0 means every beat is a single-beat packet; tkeep is forced all-ones and tlast is forced 1.
- `CNT_WIDTH`, 32: width of the statistics counters.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  `NUM_PORTS*DATA_WIDTH`  packed input data; port i is slice i.
- `s_axis_tkeep`  in  `NUM_PORTS*KEEP_WIDTH`  packed input keep.
- `s_axis_tlast`, `s_axis_tvalid`  in  `NUM_PORTS`  per-port last / valid.
- `s_axis_tready`  out  `NUM_PORTS`  per-port ready.
- `s_cond_tdata`, `s_cond_tvalid`  in  `NUM_PORTS`  per-port condition token; 1 = forward.
- `s_cond_tready`  out  `NUM_PORTS`  condition token consumed.
- `m_axis_tdata`  out  `DATA_WIDTH`  output data.
- `m_axis_tkeep`  out  `KEEP_WIDTH`  output keep.
- `m_axis_tlast`, `m_axis_tvalid`  out  1  output last / valid.
- `m_axis_tuser`  out  `$clog2(NUM_PORTS)`  source port index of the current beat.
- `m_axis_tready`  in  1  downstream ready.
- `fwd_pkt_cnt`, `drop_pkt_cnt`  out  `CNT_WIDTH`  packets forwarded / dropped; both saturate.

## Operation
- **States.** The block has two states: IDLE (arbitrating) and LOCKED (mid-packet). It also holds `grant_reg` (port index), `cond_reg`, and `rr_ptr`.
- **Eligibility (IDLE).** Port i is eligible when `s_cond_tvalid[i] && s_axis_tvalid[i]`. The winner is the first eligible port at or after `rr_ptr`, searching cyclically. A data beat without a condition token, or a token without data, is not eligible and is not consumed.
- **IDLE, winner w, cond=1.**
  - The winner's beat is driven to the output with `m_axis_tvalid=1`.
  - `s_axis_tready[w]` and `s_cond_tready[w]` equal `m_axis_tready`.
- **IDLE, winner w, cond=0.**
  - `m_axis_tvalid=0`.
  - `s_axis_tready[w]` and `s_cond_tready[w]` are 1 regardless of `m_axis_tready`.
- **First-beat transfer.** If the transferred beat is not last, the next state is LOCKED with `grant_reg=w` and `cond_reg` set to the token value. If it is last, the packet is complete.
- **LOCKED.**
  - Only `grant_reg` is served; no condition token is consumed.
  - Forwarding follows `cond_reg` with the same ready rules as IDLE.
  - The state returns to IDLE on the transfer of a last beat.
- **Packet complete.**
  - `rr_ptr` becomes the served port + 1, modulo `NUM_PORTS`.
  - `fwd_pkt_cnt` or `drop_pkt_cnt` increments by 1, stopping at all-ones.
- **Non-granted ports.** `s_axis_tready` and `s_cond_tready` are 0 for every non-granted port.
- **Output payload.** `m_axis_tdata`, `tkeep`, `tlast` and `tuser` always reflect the granted (or winning) port. They are don't-care while `m_axis_tvalid=0`.
- **Reset (rst low, at any time including mid-packet).**
  - State returns to IDLE; `rr_ptr`, `grant_reg`, `cond_reg` and both counters return to 0.
  - All `s_*_tready` and `m_axis_tvalid` are 0 while reset is asserted.
  - A partial packet upstream is not flushed; the system resets producers together.

## Timing
- **Latency.** Zero-cycle combinational pass-through: an accepted beat appears on `m_axis_*` in the same cycle.
- **Combinational paths.**
  - `m_axis_tvalid` depends on `s_axis_tvalid` and `s_cond_*`.
  - `s_axis_tready` depends on `m_axis_tready`.
  - The downstream must not make `tready` depend on `tvalid`.
- **Drop rate.** A dropped packet drains at 1 beat/cycle even while `m_axis_tready=0`.
- **Back-to-back packets.**
  - A single-beat packet completes in IDLE; a different port can win on the next cycle.
  - There are no bubble cycles between packets.
- **Simultaneous events.**
  - All ports eligible: grants go 0,1,2,3,0… starting from `rr_ptr=0` after reset.
  - The port just served loses ties for one round.
- **Counter update.** Counters update one cycle after the last-beat transfer.

## Structure
- **Shared package `ep2_arb_pkg`:** the state encoding (IDLE=0, LOCKED=1) and a `clog2`-safe index-width function, shared with future arbiters.
- **Sub-module `rr_priority_select`:** combinational, inputs `req[NUM_PORTS]` and `ptr`, outputs `valid` and `idx`. It is reused by other schedulers.
- **Top level:** state register, grant/cond registers, muxes and counters.

## Test plan
1. Reset, then ports 0–3 each present one 1-beat packet with cond=1 and `m_axis_tready=1`. Output `tuser` is 0,1,2,3 on consecutive cycles; `fwd_pkt_cnt=4`.
2. Port 1 sends a 4-beat packet with cond=1 while port 2 is eligible from cycle 1. All 4 beats have `tuser=1` with no interleave; port 2's first beat follows on the next cycle.
3. Port 0 sends a 3-beat packet with cond=0 while `m_axis_tready=0`. It drains in 3 cycles, `m_axis_tvalid` stays 0, and `drop_pkt_cnt=1`.
4. Port 3 has data valid but no cond token while port 0 is eligible. Port 0 is granted; port 3's `tready` stays 0 until its token arrives.
5. Assert `rst` low during beat 2 of a 5-beat forwarded packet. All readies and `m_axis_tvalid` go 0 immediately and counters clear. After release, the first grant is the lowest eligible port.
6. `IF_STREAM=0`, `NUM_PORTS=2`, both ports always eligible with mixed cond. Output has `tlast=1` and `tkeep` all-ones, grants alternate, and `fwd_pkt_cnt` + `drop_pkt_cnt` equals the number of accepted beats.
